// File: rtl/alu_addsub_sequencer.sv
// -----------------------------------------------------------------------------
// alu_addsub_sequencer
//
// Purpose:
//   Multi-cycle controller that time-shares a single add/subtract adder across
//   the add/subtract family of ALU operations. One operation is in flight at a
//   time. Each operation makes one adder pass, except SBCS2, which makes two
//   (a - b, then that result - 1). The block owns the architectural NZCV flag
//   register. It returns each result over a valid/ready response port.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   req_valid    request valid
//   req_ready    request accepted when req_valid && req_ready (high in IDLE only)
//   req_op       0 ADDS, 1 ADCS, 2 SUBS, 3 SBCS2, 4 RSBS, 5 NEGS, 6 CMP, 7 illegal
//   req_a        operand a
//   req_b        operand b
//   rsp_valid    response valid (held until rsp_ready)
//   rsp_ready    response consumed when rsp_valid && rsp_ready
//   rsp_result   result of the final adder pass (0 for an illegal opcode)
//   rsp_err      illegal opcode indication
//   flag_n/z/c/v registered NZCV flags, updated only by completing legal ops
//   ops_done     count of completed non-error responses, wraps to 0
// -----------------------------------------------------------------------------
module alu_addsub_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC1 = 2'd1,
        ST_EXEC2 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADDS  = 3'd0;
    localparam logic [2:0] OP_ADCS  = 3'd1;
    localparam logic [2:0] OP_SUBS  = 3'd2;
    localparam logic [2:0] OP_SBCS2 = 3'd3;
    localparam logic [2:0] OP_RSBS  = 3'd4;
    localparam logic [2:0] OP_NEGS  = 3'd5;
    localparam logic [2:0] OP_CMP   = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Signed overflow of x + y: both addends share a sign that the sum lacks.
    // For subtraction, y is already the inverted subtrahend, so the same rule holds.
    function automatic logic ovf_of(input logic x_msb, input logic y_msb, input logic s_msb);
        return (x_msb == y_msb) && (s_msb != x_msb);
    endfunction

    state_t           state_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_in_r;
    logic [WIDTH-1:0] pass1_r;

    logic [WIDTH-1:0] add_x_s;
    logic [WIDTH-1:0] add_y_s;
    logic             add_cin_s;
    logic [WIDTH-1:0] add_sum_s;
    logic             add_cout_s;
    logic             add_v_s;
    logic             accept_s;
    logic             pass_done_s;
    logic             rsp_fire_s;

    assign req_ready   = (state_r == ST_IDLE);
    assign accept_s    = req_valid && (state_r == ST_IDLE);
    assign rsp_fire_s  = rsp_ready && (state_r == ST_RESP);

    // The final pass finishes in EXEC1 for single-pass ops, and in EXEC2 for SBCS2.
    assign pass_done_s = ((state_r == ST_EXEC1) && (op_r != OP_SBCS2)) ||
                         (state_r == ST_EXEC2);

    // Shared adder. Subtraction is x + ~y + 1, so the carry-out is NOT borrow.
    assign {add_cout_s, add_sum_s} = {1'b0, add_x_s} + {1'b0, add_y_s} +
                                     {{WIDTH{1'b0}}, add_cin_s};
    assign add_v_s = ovf_of(add_x_s[WIDTH-1], add_y_s[WIDTH-1], add_sum_s[WIDTH-1]);

    // Adder operand selection for the current pass
    always_comb begin
        add_x_s   = a_r;
        add_y_s   = b_r;
        add_cin_s = 1'b0;
        if (state_r == ST_EXEC2) begin
            // Second SBCS2 pass: (a - b) - 1
            add_x_s   = pass1_r;
            add_y_s   = ~ONE_W;
            add_cin_s = 1'b1;
        end else begin
            case (op_r)
                OP_ADDS: begin
                    add_x_s   = a_r;
                    add_y_s   = b_r;
                    add_cin_s = 1'b0;
                end
                OP_ADCS: begin
                    add_x_s   = a_r;
                    add_y_s   = b_r;
                    add_cin_s = c_in_r;
                end
                OP_SUBS, OP_SBCS2, OP_CMP: begin
                    add_x_s   = a_r;
                    add_y_s   = ~b_r;
                    add_cin_s = 1'b1;
                end
                OP_RSBS: begin
                    add_x_s   = b_r;
                    add_y_s   = ~a_r;
                    add_cin_s = 1'b1;
                end
                OP_NEGS: begin
                    add_x_s   = ZERO_W;
                    add_y_s   = ~a_r;
                    add_cin_s = 1'b1;
                end
                default: begin
                    add_x_s   = a_r;
                    add_y_s   = b_r;
                    add_cin_s = 1'b0;
                end
            endcase
        end
    end

    // Control FSM plus capture of the accepted request and the pass-1 sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= 3'd0;
            a_r     <= ZERO_W;
            b_r     <= ZERO_W;
            c_in_r  <= 1'b0;
            pass1_r <= ZERO_W;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_r   <= req_op;
                        a_r    <= req_a;
                        b_r    <= req_b;
                        // ADCS consumes the carry as it stood when the op was accepted
                        c_in_r <= flag_c;
                        if (req_op == OP_ILL) begin
                            state_r <= ST_RESP;
                        end else begin
                            state_r <= ST_EXEC1;
                        end
                    end
                end
                ST_EXEC1: begin
                    pass1_r <= add_sum_s;
                    if (op_r == OP_SBCS2) begin
                        state_r <= ST_EXEC2;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                ST_EXEC2: begin
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Response registers. Held stable in RESP until the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= ZERO_W;
            rsp_err    <= 1'b0;
        end else if (accept_s && (req_op == OP_ILL)) begin
            rsp_valid  <= 1'b1;
            rsp_result <= ZERO_W;
            rsp_err    <= 1'b1;
        end else if (pass_done_s) begin
            rsp_valid  <= 1'b1;
            rsp_result <= add_sum_s;
            rsp_err    <= 1'b0;
        end else if (rsp_fire_s) begin
            rsp_valid  <= 1'b0;
        end
    end

    // NZCV flags. Written only when the final pass of a legal op completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (pass_done_s) begin
            flag_n <= add_sum_s[WIDTH-1];
            flag_z <= (add_sum_s == ZERO_W);
            flag_c <= add_cout_s;
            flag_v <= add_v_s;
        end
    end

    // Completed-operation counter. Error responses are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_done <= {CNT_W{1'b0}};
        end else if (rsp_fire_s && !rsp_err) begin
            ops_done <= ops_done + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_alu_addsub_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_addsub_sequencer
//
// Directed testbench for alu_addsub_sequencer. It drives inputs #1 after the
// rising edge and samples outputs at that same point. Every expected value is
// hand-computed. The counter is narrowed to 8 bits, so its wrap point is
// reached in a few hundred operations.
// -----------------------------------------------------------------------------
module tb_alu_addsub_sequencer;

    localparam int WIDTH_TB = 32;
    localparam int CNT_W_TB = 8;

    logic                clk;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_op;
    logic [WIDTH_TB-1:0] req_a;
    logic [WIDTH_TB-1:0] req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [WIDTH_TB-1:0] rsp_result;
    logic                rsp_err;
    logic                flag_n;
    logic                flag_z;
    logic                flag_c;
    logic                flag_v;
    logic [CNT_W_TB-1:0] ops_done;

    int n_cmp;
    int n_bad;
    int exp_done;

    alu_addsub_sequencer #(
        .WIDTH (WIDTH_TB),
        .CNT_W (CNT_W_TB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .flag_n     (flag_n),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .flag_v     (flag_v),
        .ops_done   (ops_done)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time bound for the whole run
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] nzcv();
        return {28'd0, flag_n, flag_z, flag_c, flag_v};
    endfunction

    // Issue one op with rsp_ready high. Checks latency, result, flags and counter.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_err, input logic [3:0] exp_flags);
        int lat;
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, rsp_result, exp_res);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        chk({tag, "_nzcv"}, nzcv(), {28'd0, exp_flags});
        if (!exp_err) exp_done++;
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_ops_done"}, {24'd0, ops_done}, exp_done & 255);
    endtask

    // Quiet ADDS used to step the completion counter
    task automatic quick_add();
        int k;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd1;
        req_b     = 32'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        if (!rsp_valid) chk("quick_timeout", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
    endtask

    // Main directed sequence
    initial begin
        int lat;
        n_cmp     = 0;
        n_bad     = 0;
        exp_done  = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_nzcv", nzcv(), 32'd0);
        chk("rst_ops_done", {24'd0, ops_done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        run_op("adds_wrap", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 2, 32'h0000_0000, 1'b0, 4'b0110);
        run_op("subs_5_7",  3'd2, 32'd5, 32'd7, 2, 32'hFFFF_FFFE, 1'b0, 4'b1000);
        run_op("adcs_c0",   3'd1, 32'd1, 32'd2, 2, 32'd3, 1'b0, 4'b0000);
        run_op("subs_7_5",  3'd2, 32'd7, 32'd5, 2, 32'd2, 1'b0, 4'b0010);
        run_op("adcs_c1",   3'd1, 32'd1, 32'd2, 2, 32'd4, 1'b0, 4'b0000);
        run_op("sbcs2_min", 3'd3, 32'h8000_0000, 32'd0, 3, 32'h7FFF_FFFF, 1'b0, 4'b0011);
        run_op("sbcs2_eq",  3'd3, 32'd3, 32'd3, 3, 32'hFFFF_FFFF, 1'b0, 4'b1000);
        run_op("rsbs",      3'd4, 32'd1, 32'd0, 2, 32'hFFFF_FFFF, 1'b0, 4'b1000);
        run_op("negs_min",  3'd5, 32'h8000_0000, 32'd0, 2, 32'h8000_0000, 1'b0, 4'b1001);
        run_op("cmp_5_3",   3'd6, 32'd5, 32'd3, 2, 32'd2, 1'b0, 4'b0010);
        run_op("illegal",   3'd7, 32'd9, 32'd9, 1, 32'd0, 1'b1, 4'b0010);

        // Backpressure: hold the SUBS response for 5 cycles while a second request waits
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = 3'd2;
        req_a     = 32'd7;
        req_b     = 32'd5;
        @(posedge clk); #1;
        req_op = 3'd0;
        req_a  = 32'd10;
        req_b  = 32'd20;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", lat, 32'd2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_hold_result", rsp_result, 32'd2);
            chk("bp_hold_nzcv", nzcv(), 32'b0010);
            chk("bp_hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_done++;
        chk("bp_release_idle", {31'd0, req_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_release_ops_done", {24'd0, ops_done}, exp_done & 255);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_second_accepted", {31'd0, req_ready}, 32'd0);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_second_latency", lat, 32'd2);
        chk("bp_second_result", rsp_result, 32'd30);
        chk("bp_second_nzcv", nzcv(), 32'b0000);
        @(posedge clk); #1;
        exp_done++;
        chk("bp_second_ops_done", {24'd0, ops_done}, exp_done & 255);

        run_op("negs_one", 3'd5, 32'd1, 32'd0, 2, 32'hFFFF_FFFF, 1'b0, 4'b1000);

        // Reset while SBCS2 is in its second pass
        req_valid = 1'b1;
        req_op    = 3'd3;
        req_a     = 32'd9;
        req_b     = 32'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_nzcv", nzcv(), 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_ops_done", {24'd0, ops_done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        chk("midrst_idle", {31'd0, req_ready}, 32'd1);

        // Counter wrap at 2^CNT_W completions
        for (int i = 0; i < 255; i++) quick_add();
        chk("wrap_before", {24'd0, ops_done}, 32'd255);
        quick_add();
        chk("wrap_after", {24'd0, ops_done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
